// File: rtl/mem_burst_write_master.sv
// Avalon-MM burst write master fed by an internal show-ahead FIFO.
// A transfer is a byte base/length pair; data is drained in bursts of up to MAXBURSTCOUNT beats.
module mem_burst_write_master #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = DATAWIDTH / 8,
    parameter int ADDRESSWIDTH    = 30,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5,
    parameter int MAXBURSTCOUNT   = 8,
    parameter int BURSTCOUNTWIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDRESSWIDTH-1:0]     control_write_base,
    input  logic [ADDRESSWIDTH-1:0]     control_write_length,
    input  logic                        control_go,
    output logic                        control_done,
    output logic                        control_busy,
    input  logic                        user_write_buffer,
    input  logic [DATAWIDTH-1:0]        user_buffer_data,
    output logic                        user_buffer_full,
    output logic [FIFODEPTH_LOG2:0]     user_buffer_usedw,
    output logic [ADDRESSWIDTH-1:0]     master_address,
    output logic                        master_write,
    output logic [BYTEENABLEWIDTH-1:0]  master_byteenable,
    output logic [DATAWIDTH-1:0]        master_writedata,
    output logic [BURSTCOUNTWIDTH-1:0]  master_burstcount,
    input  logic                        master_waitrequest
);

    localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0]   BE_BYTES  = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0]   LEN_MASK  = ~(ADDRESSWIDTH'(BYTEENABLEWIDTH - 1));
    localparam logic [ADDRESSWIDTH-1:0]   MAX_BURST = ADDRESSWIDTH'(MAXBURSTCOUNT);
    localparam logic [FIFODEPTH_LOG2:0]   DEPTH_W   = (FIFODEPTH_LOG2 + 1)'(FIFODEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATAWIDTH-1:0]      fifo_mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FIFODEPTH_LOG2:0]   usedw_reg, usedw_next;
    logic                      full_reg, full_next;
    logic                      push, pop;

    // ------------------------------------------------------------------
    // Transfer control
    // ------------------------------------------------------------------
    state_t                     state_reg, state_next;
    logic [ADDRESSWIDTH-1:0]    length_reg, length_next;
    logic [ADDRESSWIDTH-1:0]    addr_reg, addr_next;
    logic [ADDRESSWIDTH-1:0]    master_address_reg, master_address_next;
    logic [BURSTCOUNTWIDTH-1:0] burstcount_reg, burstcount_next;
    logic [BURSTCOUNTWIDTH-1:0] beat_cnt_reg, beat_cnt_next;
    logic [ADDRESSWIDTH-1:0]    masked_length;
    logic [ADDRESSWIDTH-1:0]    rem_words;
    logic [ADDRESSWIDTH-1:0]    bw_words;
    logic [ADDRESSWIDTH-1:0]    usedw_ext;
    logic                       beat_accept;

    // A push is judged against the registered full flag, so a simultaneous pop never rescues it.
    assign push        = user_write_buffer & ~full_reg;
    assign beat_accept = master_write & ~master_waitrequest;
    assign pop         = beat_accept & (usedw_reg != '0);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        usedw_next  = usedw_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   usedw_next = usedw_reg + 1'b1;
            2'b01:   usedw_next = usedw_reg - 1'b1;
            default: usedw_next = usedw_reg;
        endcase
        full_next = (usedw_next == DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= user_buffer_data;
        end
    end

    assign masked_length = control_write_length & LEN_MASK;
    assign rem_words     = length_reg >> BE_LOG2;
    assign bw_words      = (rem_words > MAX_BURST) ? MAX_BURST : rem_words;
    assign usedw_ext     = ADDRESSWIDTH'(usedw_reg);

    always_comb begin
        state_next          = state_reg;
        length_next         = length_reg;
        addr_next           = addr_reg;
        master_address_next = master_address_reg;
        burstcount_next     = burstcount_reg;
        beat_cnt_next       = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (control_go) begin
                    addr_next   = control_write_base;
                    length_next = masked_length;
                    if (masked_length != '0) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Only start once the whole burst is buffered so write never drops mid-burst.
                if (usedw_ext >= bw_words) begin
                    burstcount_next     = bw_words[BURSTCOUNTWIDTH-1:0];
                    beat_cnt_next       = bw_words[BURSTCOUNTWIDTH-1:0];
                    master_address_next = addr_reg;
                    state_next          = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_accept) begin
                    beat_cnt_next = beat_cnt_reg - 1'b1;
                    length_next   = length_reg - BE_BYTES;
                    addr_next     = addr_reg + BE_BYTES;
                    if (beat_cnt_reg == BURSTCOUNTWIDTH'(1)) begin
                        state_next = (length_reg == BE_BYTES) ? ST_IDLE : ST_WAIT;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            length_reg         <= '0;
            addr_reg           <= '0;
            master_address_reg <= '0;
            burstcount_reg     <= '0;
            beat_cnt_reg       <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            usedw_reg          <= '0;
            full_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            length_reg         <= length_next;
            addr_reg           <= addr_next;
            master_address_reg <= master_address_next;
            burstcount_reg     <= burstcount_next;
            beat_cnt_reg       <= beat_cnt_next;
            wr_ptr_reg         <= wr_ptr_next;
            rd_ptr_reg         <= rd_ptr_next;
            usedw_reg          <= usedw_next;
            full_reg           <= full_next;
        end
    end

    // master_write comes straight from the state register so reset removes it at once.
    assign master_write      = (state_reg == ST_BURST);
    assign master_address    = master_address_reg;
    assign master_burstcount = burstcount_reg;
    assign master_writedata  = fifo_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < BYTEENABLEWIDTH; gi++) begin : g_byteenable
            assign master_byteenable[gi] = 1'b1;
        end
    endgenerate

    assign user_buffer_usedw = usedw_reg;
    assign user_buffer_full  = full_reg;
    assign control_done      = (state_reg == ST_IDLE) && (length_reg == '0);
    assign control_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_write_master.sv
// Directed bench for mem_burst_write_master: a table of transfers checked against a FIFO scoreboard,
// plus hand-written sequences for overflow, reset mid-burst and reset state.
module tb_mem_burst_write_master;

    logic        clk;
    logic        reset_n;
    logic [29:0] control_write_base;
    logic [29:0] control_write_length;
    logic        control_go;
    logic        control_done;
    logic        control_busy;
    logic        user_write_buffer;
    logic [31:0] user_buffer_data;
    logic        user_buffer_full;
    logic [5:0]  user_buffer_usedw;
    logic [29:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic [3:0]  master_burstcount;
    logic        master_waitrequest;

    mem_burst_write_master dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .control_write_base   (control_write_base),
        .control_write_length (control_write_length),
        .control_go           (control_go),
        .control_done         (control_done),
        .control_busy         (control_busy),
        .user_write_buffer    (user_write_buffer),
        .user_buffer_data     (user_buffer_data),
        .user_buffer_full     (user_buffer_full),
        .user_buffer_usedw    (user_buffer_usedw),
        .master_address       (master_address),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_burstcount    (master_burstcount),
        .master_waitrequest   (master_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          prefill;
        logic [29:0] base;
        logic [29:0] len;
        int          stall_beat;
        int          stall_len;
        bit          push_during;
        bit          go_during;
        int          exp_bursts;
        int          exp_latency;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_data = 32'hD000_0000;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int prefill, input logic [29:0] base, input logic [29:0] len,
                                input int stall_beat, input int stall_len, input bit push_during,
                                input bit go_during, input int exp_bursts, input int exp_latency);
        vec_t v;
        v.prefill = prefill; v.base = base; v.len = len;
        v.stall_beat = stall_beat; v.stall_len = stall_len;
        v.push_during = push_during; v.go_during = go_during;
        v.exp_bursts = exp_bursts; v.exp_latency = exp_latency;
        return v;
    endfunction

    // Drive one word for the next edge; the model keeps it only if the FIFO was not full.
    task automatic drive_push();
        user_write_buffer = 1'b1;
        user_buffer_data  = next_data;
        if (exp_q.size() < 32) exp_q.push_back(next_data);
        next_data = next_data + 32'd1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_push();
        end
        @(negedge clk);
        user_write_buffer = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          words, consumed, burst_left, bursts, first_cyc, stall_cnt, pushed, beat_idx, exp_bc;
        bit          go_sent;
        logic [29:0] exp_addr;
        logic [5:0]  held_usedw;
        words = 0; consumed = 0; burst_left = 0; bursts = 0; first_cyc = -1;
        stall_cnt = 0; pushed = 0; beat_idx = 0; exp_bc = 0; go_sent = 1'b0;
        exp_addr = '0; held_usedw = '0;
        if (v.prefill > 0) push_words(v.prefill);
        @(negedge clk);
        control_go = 1'b1; control_write_base = v.base; control_write_length = v.len;
        @(negedge clk);
        control_go = 1'b0;
        words = int'(v.len >> 2);
        if (words == 0) begin
            chk({tag, "_zero_busy"}, control_busy, 0);
            chk({tag, "_zero_write"}, master_write, 0);
            @(negedge clk);
            chk({tag, "_zero_done"}, control_done, 1);
            $display("transfer %s base=%0h len=%0h beats=0", tag, v.base, v.len);
            return;
        end
        for (int cyc = 0; cyc < 400 && consumed < words; cyc++) begin
            if (v.push_during && pushed < 8) begin
                drive_push();
                pushed++;
            end else begin
                user_write_buffer = 1'b0;
            end
            control_go = 1'b0;
            if (master_write) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (burst_left == 0) begin
                    exp_bc     = (words - consumed > 8) ? 8 : words - consumed;
                    exp_addr   = v.base + 30'(consumed * 4);
                    burst_left = exp_bc;
                    bursts++;
                    chk({tag, "_data_ready"}, (int'(user_buffer_usedw) >= exp_bc), 1);
                end
                chk({tag, "_addr"}, master_address, exp_addr);
                chk({tag, "_bcount"}, master_burstcount, exp_bc);
                chk({tag, "_data"}, master_writedata, exp_q.size() > 0 ? exp_q[0] : 32'hx);
                if (v.go_during && beat_idx == 2 && !go_sent) begin
                    control_go = 1'b1; control_write_base = 30'h900; control_write_length = 30'h40;
                    go_sent = 1'b1;
                end
                if (beat_idx == v.stall_beat && stall_cnt < v.stall_len) begin
                    master_waitrequest = 1'b1;
                    stall_cnt++;
                    if (stall_cnt == 1) held_usedw = user_buffer_usedw;
                    else chk({tag, "_stall_usedw"}, user_buffer_usedw, held_usedw);
                end else begin
                    master_waitrequest = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    consumed++;
                    burst_left--;
                    beat_idx++;
                end
            end else begin
                master_waitrequest = 1'b0;
                if (burst_left > 0) chk({tag, "_no_gap"}, master_write, 1);
            end
            @(negedge clk);
        end
        user_write_buffer = 1'b0; master_waitrequest = 1'b0; control_go = 1'b0;
        chk({tag, "_timeout"}, consumed, words);
        chk({tag, "_done"}, control_done, 1);
        chk({tag, "_busy"}, control_busy, 0);
        chk({tag, "_write_end"}, master_write, 0);
        chk({tag, "_usedw_end"}, user_buffer_usedw, exp_q.size());
        chk({tag, "_bursts"}, bursts, v.exp_bursts);
        if (v.exp_latency >= 0) chk({tag, "_latency"}, first_cyc, v.exp_latency);
        $display("transfer %s base=%0h len=%0h beats=%0d bursts=%0d", tag, v.base, v.len, consumed, bursts);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  acc;
        bit  hit;
        reset_n = 1'b0; control_go = 1'b0; control_write_base = '0; control_write_length = '0;
        user_write_buffer = 1'b0; user_buffer_data = '0; master_waitrequest = 1'b0;

        vecs[0] = mk(8,  30'h100,        30'd32, -1, 0, 0, 0, 1, 1);
        vecs[1] = mk(10, 30'h0,          30'd40, -1, 0, 0, 0, 2, 1);
        vecs[2] = mk(0,  30'h40,         30'd32, -1, 0, 1, 0, 1, -1);
        vecs[3] = mk(8,  30'h300,        30'd32,  3, 3, 0, 0, 1, 1);
        vecs[4] = mk(8,  30'h200,        30'd32, -1, 0, 0, 1, 1, 1);
        vecs[5] = mk(10, 30'h3FFF_FFF0,  30'd43, -1, 0, 0, 0, 2, 1);
        vecs[6] = mk(0,  30'h500,        30'd3,  -1, 0, 0, 0, 0, -1);

        repeat (3) @(negedge clk);
        chk("rst_usedw", user_buffer_usedw, 0);
        chk("rst_full", user_buffer_full, 0);
        chk("rst_write", master_write, 0);
        chk("rst_bcount", master_burstcount, 0);
        chk("rst_addr", master_address, 0);
        chk("rst_done", control_done, 1);
        chk("rst_busy", control_busy, 0);
        chk("rst_byteen", master_byteenable, 4'hF);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Overflow: 33 pushes with no transfer running, then drain everything that was kept.
        push_words(32);
        chk("ovf_usedw32", user_buffer_usedw, 32);
        chk("ovf_full32", user_buffer_full, 1);
        push_words(1);
        chk("ovf_usedw33", user_buffer_usedw, 32);
        chk("ovf_full33", user_buffer_full, 1);
        $display("transfer ovf pushes=33 kept=%0d", exp_q.size());
        run_vec(mk(0, 30'h800, 30'd128, -1, 0, 0, 0, 4, 1), "ovf_drain");
        chk("ovf_full_end", user_buffer_full, 0);

        // Reset asserted while the third beat is on the bus.
        push_words(8);
        @(negedge clk);
        control_go = 1'b1; control_write_base = 30'h600; control_write_length = 30'd32;
        @(negedge clk);
        control_go = 1'b0;
        acc = 0; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (master_write) begin
                if (acc == 2) begin
                    reset_n = 1'b0;
                    #1;
                    chk("mrst_write", master_write, 0);
                    chk("mrst_busy", control_busy, 0);
                    chk("mrst_done", control_done, 1);
                    chk("mrst_usedw", user_buffer_usedw, 0);
                    hit = 1'b1;
                end else begin
                    acc++;
                end
            end
            if (!hit) @(negedge clk);
        end
        chk("mrst_reached", hit, 1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_post_usedw", user_buffer_usedw, 0);
        chk("mrst_post_done", control_done, 1);
        chk("mrst_post_write", master_write, 0);
        $display("transfer mrst beats_before_reset=%0d", acc);
        run_vec(mk(8, 30'h700, 30'd32, -1, 0, 0, 0, 1, 1), "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_burst_write_master.md
Name: mem_burst_write_master

Overview:
- Parametrised successor to the single-word write-buffer master.
- User logic pushes words into an internal RTL show-ahead FIFO; the block drains them to memory as Avalon-MM bursts.
- Each transfer is defined by a byte base address and a byte length.
- Adds burst transfers, FIFO fill reporting, a busy flag, and a defined go/busy interlock; width and depth are generic.

Parameters:
- DATAWIDTH, 32, data bus width in bits (multiple of 8).
- BYTEENABLEWIDTH, DATAWIDTH/8, bytes per word.
- ADDRESSWIDTH, 30, byte address and length width.
- FIFODEPTH, 32, FIFO words (power of 2).
- FIFODEPTH_LOG2, 5, log2(FIFODEPTH).
- MAXBURSTCOUNT, 8, maximum beats per burst (power of 2, <= FIFODEPTH).
- BURSTCOUNTWIDTH, 4, width of master_burstcount; holds MAXBURSTCOUNT.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- control_write_base  in  ADDRESSWIDTH  byte start address (word aligned).
- control_write_length  in  ADDRESSWIDTH  byte count; low log2(BYTEENABLEWIDTH) bits are ignored.
- control_go  in  1  one-cycle start strobe.
- control_done  out  1  high when idle with zero bytes remaining.
- control_busy  out  1  high while a transfer is in progress.
- user_write_buffer  in  1  push strobe.
- user_buffer_data  in  DATAWIDTH  push data.
- user_buffer_full  out  1  FIFO holds FIFODEPTH words.
- user_buffer_usedw  out  FIFODEPTH_LOG2+1  FIFO fill level, 0..FIFODEPTH.
- master_address  out  ADDRESSWIDTH  burst start byte address.
- master_write  out  1  write request.
- master_byteenable  out  BYTEENABLEWIDTH  all ones.
- master_writedata  out  DATAWIDTH  FIFO head word.
- master_burstcount  out  BURSTCOUNTWIDTH  beats in the current burst.
- master_waitrequest  in  1  slave stall.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, length=0, address=0, FIFO empty.
  - Resulting outputs: usedw=0, full=0, master_write=0, burstcount=0, done=1, busy=0.
  - Reset asserted mid-burst drops master_write immediately and discards the FIFO contents.
- FIFO:
  - Show-ahead: master_writedata equals the head word combinationally.
  - A push while full is dropped; this holds even if a pop occurs in the same cycle.
  - Pop happens only on beat acceptance and is never issued when empty.
  - Simultaneous push and pop leaves usedw unchanged.
  - usedw and full are registered and reflect the previous edge.
- Beat accepted when master_write=1 and master_waitrequest=0.
- Words remaining: rem = length >> log2(BYTEENABLEWIDTH).
- Burst size: bw = min(MAXBURSTCOUNT, rem).
- States:
  - IDLE: control_go=1 loads address=base and length=length & ~(BYTEENABLEWIDTH-1).
    - Next state is WAIT if the masked length is nonzero, else stay IDLE.
    - control_go while busy (WAIT or BURST) is ignored.
  - WAIT: when usedw >= bw, register master_burstcount=bw and beat counter=bw, and go to BURST on the next edge.
    - master_write=0 in WAIT.
  - BURST: master_write=1 continuously.
    - master_address and master_burstcount are held stable for the whole burst.
    - Each accepted beat: pop FIFO, beat counter -1, length -= BYTEENABLEWIDTH, internal next-address += BYTEENABLEWIDTH.
    - On the last accepted beat: go to IDLE if length reaches 0, else WAIT.
    - master_address takes the next address on entry to BURST.
- Bursts only start with a full burst's worth of data buffered, so master_write never deasserts mid-burst.
- Latency: first beat is presented 2 cycles after go if the FIFO already holds bw words.
- waitrequest stall: all master outputs are held, including writedata, because no pop occurs.
- Outputs:
  - control_done = (state==IDLE) & (length==0).
  - control_busy = (state!=IDLE).
- Address arithmetic wraps modulo 2^ADDRESSWIDTH without error.

Test Plan:
- Prefill 8 words D0..D7; go with base=0x100, len=32 -> exactly one burst: address 0x100, burstcount 8, writedata D0..D7 on consecutive beats; then done=1, usedw=0.
- Prefill 10 words; go with base=0, len=40 -> burst of 8 at 0x0, then burst of 2 at 0x20; done=1.
- Go with len=32 and FIFO empty, then push 1 word per cycle -> master_write stays 0 until usedw=8; burst then completes with no gaps.
- Assert waitrequest for 3 cycles on beat 4 -> address, burstcount and writedata held for 3 cycles; 8 beats total; usedw decrements only on accepted beats.
- Push 33 words with no go -> full=1 and usedw=32 after 32 pushes; 33rd word dropped; the following drain writes the first 32 words in order.
- Assert reset_n=0 at beat 3 of a burst -> master_write=0 in the same cycle; after release usedw=0, done=1. Go during BURST -> ignored; address and length unchanged.
